// File: rtl/farbborg_pkg.sv
// Shared encodings and field widths for the farbborg PWM scan path.
package farbborg_pkg;

  localparam int unsigned LAYER_W = 3;
  localparam int unsigned WORD_W  = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned LANES   = 8;
  localparam int unsigned ADDR_W  = LAYER_W + WORD_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_LATCH    = 3'd4,
    S_ADVANCE  = 3'd5
  } state_e;

endpackage

// File: rtl/farbborg_pwm_cmp.sv
// Per-lane PWM decision: lane i is lit while its brightness byte exceeds the step.
module farbborg_pwm_cmp
  import farbborg_pkg::*;
(
  input  logic [LANES*BYTE_W-1:0] word_i,
  input  logic [BYTE_W-1:0]       step_i,
  output logic [LANES-1:0]        gt_o
);

  always_comb begin
    gt_o = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      gt_o[i] = (word_i[i*BYTE_W +: BYTE_W] > step_i);
    end
  end

endmodule

// File: rtl/farbborg_pwm_scan.sv
// Frame-buffer scanner: walks layers/words, emits PWM bits to eight LED
// shift-register lanes with shift clock, latch, blank and layer select.
module farbborg_pwm_scan
  import farbborg_pkg::*;
#(
  parameter int unsigned NUM_LAYERS      = 8,
  parameter int unsigned WORDS_PER_LAYER = 16,
  parameter int unsigned PWM_STEPS       = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  output logic [ADDR_W-1:0]       addr_o,
  input  logic [LANES*BYTE_W-1:0] data_i,
  output logic [LANES-1:0]        sdo_o,
  output logic                    sclk_o,
  output logic                    latch_o,
  output logic                    blank_o,
  output logic [NUM_LAYERS-1:0]   layer_o,
  output logic                    frame_o
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(WORDS_PER_LAYER - 1);
  localparam logic [BYTE_W-1:0]  LAST_STEP  = BYTE_W'(PWM_STEPS - 1);

  state_e                  state_q, state_d;
  logic [LAYER_W-1:0]      layer_q, layer_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [BYTE_W-1:0]       step_q, step_d;
  logic [LANES-1:0]        sdo_q, sdo_d;
  logic                    blank_hold_q, blank_hold_d;
  logic [NUM_LAYERS-1:0]   layer_sel_q, layer_sel_d;
  logic [NUM_LAYERS-1:0]   layer_onehot;
  logic [LANES-1:0]        cmp_gt;

  farbborg_pwm_cmp u_cmp (
    .word_i (data_i),
    .step_i (step_q),
    .gt_o   (cmp_gt)
  );

  always_comb begin
    layer_onehot = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      layer_onehot[i] = (layer_q == LAYER_W'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    word_d       = word_q;
    step_d       = step_q;
    sdo_d        = sdo_q;
    blank_hold_d = blank_hold_q;
    layer_sel_d  = layer_sel_q;
    case (state_q)
      S_IDLE: begin
        blank_hold_d = 1'b1;
        layer_sel_d  = '0;
        if (enable_i) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_SHIFT_LO;
      S_SHIFT_LO: begin
        sdo_d   = cmp_gt;
        state_d = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (word_q == LAST_WORD) begin
          word_d  = '0;
          state_d = S_LATCH;
        end else begin
          word_d  = word_q + WORD_W'(1);
          state_d = S_FETCH;
        end
        // Dropping enable abandons the step without a latch; the word pointer
        // still advances so a resume continues with the next word.
        if (!enable_i) state_d = S_IDLE;
      end
      S_LATCH: begin
        layer_sel_d = layer_onehot;
        state_d     = S_ADVANCE;
      end
      S_ADVANCE: begin
        blank_hold_d = 1'b0;
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          layer_d = (layer_q == LAST_LAYER) ? '0 : layer_q + LAYER_W'(1);
        end else begin
          step_d = step_q + BYTE_W'(1);
        end
        state_d = enable_i ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      layer_q      <= '0;
      word_q       <= '0;
      step_q       <= '0;
      sdo_q        <= '0;
      blank_hold_q <= 1'b1;
      layer_sel_q  <= '0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      word_q       <= word_d;
      step_q       <= step_d;
      sdo_q        <= sdo_d;
      blank_hold_q <= blank_hold_d;
      layer_sel_q  <= layer_sel_d;
    end
  end

  // Step 0 latches a new layer's first data, so the outputs stay dark for that
  // cycle while the layer select is swapped underneath.
  always_comb begin
    case (state_q)
      S_IDLE:    blank_o = 1'b1;
      S_LATCH:   blank_o = (step_q == '0);
      S_ADVANCE: blank_o = 1'b0;
      default:   blank_o = blank_hold_q;
    endcase
  end

  assign addr_o  = {layer_q, word_q};
  assign sdo_o   = sdo_q;
  assign sclk_o  = (state_q == S_SHIFT_HI);
  assign latch_o = (state_q == S_LATCH);
  assign layer_o = (state_q == S_IDLE) ? '0 : layer_sel_q;
  assign frame_o = (state_q == S_ADVANCE) && (step_q == LAST_STEP) &&
                   (layer_q == LAST_LAYER);

endmodule

// File: tb/tb_farbborg_pwm_scan.sv
// Directed bench for farbborg_pwm_scan: a default-size instance plus a tiny
// instance used for frame wrap and parameter-bound checks.
module tb_farbborg_pwm_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i, en_s;
  logic [6:0]  addr_o, addr_s;
  logic [63:0] data_i, data_s;
  logic [7:0]  sdo_o, sdo_s;
  logic        sclk_o, latch_o, blank_o, frame_o;
  logic        sclk_s, latch_s, blank_s, frame_s;
  logic [7:0]  layer_o;
  logic [1:0]  layer_s;
  logic [63:0] mem [128];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  farbborg_pwm_scan dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .addr_o(addr_o),
    .data_i(data_i), .sdo_o(sdo_o), .sclk_o(sclk_o), .latch_o(latch_o),
    .blank_o(blank_o), .layer_o(layer_o), .frame_o(frame_o)
  );

  farbborg_pwm_scan #(.NUM_LAYERS(2), .WORDS_PER_LAYER(2), .PWM_STEPS(3)) dut_s (
    .clk(clk), .reset(reset), .enable_i(en_s), .addr_o(addr_s),
    .data_i(data_s), .sdo_o(sdo_s), .sclk_o(sclk_s), .latch_o(latch_s),
    .blank_o(blank_s), .layer_o(layer_s), .frame_o(frame_s)
  );

  // Registered read port of the frame buffer.
  always @(posedge clk) begin
    data_i <= mem[addr_o];
    data_s <= mem[addr_s];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int first_sclk, first_latch, n_latch, n_frame, c0, c100, c255;
    int n_blank, bad_layer, bad_addr, f1, f2, n_l3, good_chg, bad_chg, lb;
    logic [7:0] prev_layer;
    logic found;

    for (int i = 0; i < 128; i++) mem[i] = 64'h0;
    mem[0] = 64'h00_01_7F_80_FE_FF_10_00;
    mem[1] = 64'h64_64_64_64_64_64_64_64;

    reset = 1'b1; enable_i = 1'b0; en_s = 1'b0;
    tick(); tick();
    check("rst_addr",  addr_o,  0);
    check("rst_sdo",   sdo_o,   0);
    check("rst_sclk",  sclk_o,  0);
    check("rst_latch", latch_o, 0);
    check("rst_blank", blank_o, 1);
    check("rst_layer", layer_o, 0);
    check("rst_frame", frame_o, 0);
    reset = 1'b0;
    tick();

    // Small instance: 2 layers x 2 words x 3 steps = 8 cycles/step, 48/frame.
    en_s = 1'b1;
    n_frame = 0; f1 = 0; f2 = 0; bad_addr = 0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (frame_s) begin
        n_frame++;
        if (f1 == 0) f1 = c; else if (f2 == 0) f2 = c;
      end
      if (addr_s[3:0] > 4'd1 || addr_s[6:4] > 3'd1) bad_addr++;
      if (c == 31) begin
        check("s_l1_latch_blank", {latch_s, blank_s}, 2'b11);
        check("s_l1_old_layer", layer_s, 2'b01);
      end
      if (c == 32) check("s_l1_new_layer", layer_s, 2'b10);
      if (c == 56) check("s_wrap_layer", layer_s, 2'b01);
    end
    check("s_frame_count", n_frame, 2);
    check("s_frame_first", f1, 48);
    check("s_frame_second", f2, 96);
    check("s_addr_bounds", bad_addr, 0);
    en_s = 1'b0;

    // Main instance: one full layer visit plus the step-0 latch of layer 1.
    enable_i = 1'b1;
    first_sclk = 0; first_latch = 0; n_latch = 0; n_frame = 0;
    c0 = 0; c100 = 0; c255 = 0; n_blank = 0; bad_layer = 0;
    for (int c = 1; c <= 12800; c++) begin
      tick();
      if (c <= 48 && (c % 3) == 1) check("addr_seq", addr_o, 64'(c / 3));
      if (sclk_o && first_sclk == 0) first_sclk = c;
      if (latch_o && first_latch == 0) first_latch = c;
      if (c <= 12750) begin
        if (latch_o) n_latch++;
        if (sclk_o && addr_o == 7'h00 && sdo_o[0]) c0++;
        if (sclk_o && addr_o == 7'h00 && sdo_o[2]) c255++;
        if (sclk_o && addr_o == 7'h01 && sdo_o[0]) c100++;
      end
      if (frame_o) n_frame++;
      if (c >= 51 && blank_o) n_blank++;
      if (c >= 50 && c <= 12798 && layer_o != 8'h01) bad_layer++;
      if (c == 3)     check("sdo_step0", sdo_o, 8'b0111_1110);
      if (c == 49)    check("first_latch_blank", blank_o, 1);
      if (c == 49)    check("first_latch_layer", layer_o, 8'h00);
      if (c == 50)    check("layer_after_latch", layer_o, 8'h01);
      if (c == 6353)  check("sdo_step127", sdo_o, 8'b0001_1100);
      if (c == 12751) check("addr_layer1", addr_o, 7'h10);
      if (c == 12799) check("l1_latch_blank", {latch_o, blank_o, layer_o}, {2'b11, 8'h01});
      if (c == 12800) check("l1_layer", {blank_o, layer_o}, {1'b0, 8'h02});
    end
    check("first_sclk", first_sclk, 3);
    check("first_latch", first_latch, 49);
    check("latches_per_layer", n_latch, 255);
    check("byte0_on_steps", c0, 0);
    check("byte100_on_steps", c100, 100);
    check("byte255_on_steps", c255, 255);
    check("blank_per_change", n_blank, 1);
    check("layer0_steady", bad_layer, 0);
    check("no_frame_layer0", n_frame, 0);

    // Drop enable during a FETCH cycle.
    tick();
    check("drop_fetch_addr", {sclk_o, addr_o}, {1'b0, 7'h10});
    enable_i = 1'b0;
    tick(); tick();
    check("drop_last_sclk", sclk_o, 1);
    n_latch = 0; c0 = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) check("drop_idle_outputs", {blank_o, layer_o}, {1'b1, 8'h00});
      if (latch_o) n_latch++;
      if (sclk_o) c0++;
    end
    check("drop_no_latch", n_latch, 0);
    check("drop_no_sclk", c0, 0);
    enable_i = 1'b1;
    tick();
    check("resume_addr", {sclk_o, addr_o}, {1'b0, 7'h11});

    // Run into layer 3, tracking the layer walk and the per-change blanks.
    found = 1'b0; n_l3 = 0; n_frame = 0; good_chg = 0; bad_chg = 0; lb = 0;
    prev_layer = layer_o;
    for (int c = 0; c < 40000; c++) begin
      tick();
      if (frame_o) n_frame++;
      if (latch_o && blank_o) lb++;
      if (layer_o != prev_layer && layer_o != 8'h00 && prev_layer != 8'h00) begin
        if (layer_o == (prev_layer << 1)) good_chg++; else bad_chg++;
      end
      prev_layer = layer_o;
      if (latch_o && layer_o == 8'h08) n_l3++;
      if (n_l3 >= 10 && sclk_o) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_layer3", found, 1);
    check("layer3_addr", addr_o[6:4], 3'd3);
    check("walk_good", good_chg, 2);
    check("walk_bad", bad_chg, 0);
    check("walk_blanks", lb, 2);
    check("no_frame_mid", n_frame, 0);

    // Reset in SHIFT_HI mid-layer 3.
    reset = 1'b1;
    tick();
    check("mrst_outputs", {addr_o, sdo_o, sclk_o, latch_o, blank_o, layer_o, frame_o},
          {7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});
    reset = 1'b0;
    tick();
    check("mrst_restart_addr", addr_o, 7'h00);
    first_latch = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) tick();
      if (latch_o && first_latch == 0) first_latch = c;
    end
    check("mrst_first_latch", first_latch, 49);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
